i2c_master_ctrl: RTL and testbench

- Command-driven I2C master that generates the bus conditions the slave-side detector decodes: START, repeated START, STOP, and 9-bit byte transfers (8 data bits + ACK).
- Drives SCL/SDA as open-drain enables; samples the bus through input pads.
- Sits between on-chip control logic and the I2C pads; single master only, no arbitration.

---
 rtl/i2c_master_ctrl_if.sv | 27 ++
 rtl/i2c_master_ctrl.sv | 142 ++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: command handshake and open-drain pad bundle for the I2C master
// master modport: controller side (takes commands and pad levels, drives status and pad enables)
// slave modport: issuing logic / pad side
interface i2c_master_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] data_in;
  logic       ack_in;
  logic       cmd_ready;
  logic       done;
  logic       err;
  logic [7:0] data_out;
  logic       ack_out;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;
  modport master (
    input  cmd_valid, cmd, data_in, ack_in, scl_in, sda_in,
    output cmd_ready, done, err, data_out, ack_out, busy, scl_oe, sda_oe
  );
  modport slave (
    output cmd_valid, cmd, data_in, ack_in, scl_in, sda_in,
    input  cmd_ready, done, err, data_out, ack_out, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: command-driven single-master I2C controller (START, STOP, byte WRITE/READ)
// Ports: clk, rst (sync, active high); bus (i2c_master_ctrl_if.master) carries the
// cmd_valid/cmd_ready handshake, data_in/ack_in, done/err/data_out/ack_out/busy status,
// and the open-drain scl_oe/sda_oe enables with scl_in/sda_in pad levels.
// Define I2C_STRETCH_EN to honour slave clock stretching on every SCL release quarter.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input logic               clk,
  input logic               rst,
  i2c_master_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;
  state_t     state, state_n;
  logic [1:0] q, q_n;
  logic [7:0] qc, qc_n;
  logic [3:0] bc, bc_n;
  logic       rd, rd_n;
  logic [7:0] byt, byt_n;
  logic       ack_m, ack_m_n;
  logic       err_r, err_n;
  logic       busy_r, busy_n;
  logic       scl_r, scl_n;
  logic       sda_r, sda_n;
  logic [7:0] sh;
  logic       ack_s;
  logic [7:0] data_out_r;
  logic       ack_out_r;
  logic       active, tick, hold, last_q, bitv;
  assign active = state inside {START, BIT, STOP};
  assign tick   = active && qc == 8'(CLK_DIV - 1);
  assign last_q = tick && q == 2'd3;
`ifdef I2C_STRETCH_EN
  // Q1 is the only quarter that releases SCL; wait there until the pad really goes high.
  assign hold = active && q == 2'd1 && qc == 8'd0 && !bus.scl_in;
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    state_n = state;
    q_n     = tick ? q + 2'd1 : q;
    qc_n    = (!active || tick || hold) ? 8'd0 : qc + 8'd1;
    bc_n    = bc;
    rd_n    = rd;
    byt_n   = byt;
    ack_m_n = ack_m;
    err_n   = err_r;
    busy_n  = busy_r;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        rd_n    = bus.cmd == 2'd2;
        byt_n   = bus.data_in;
        ack_m_n = bus.ack_in;
        err_n   = !busy_r && bus.cmd != 2'd0;
        q_n     = 2'd0;
        bc_n    = 4'd0;
        state_n = err_n ? DONE : bus.cmd == 2'd0 ? START : bus.cmd == 2'd3 ? STOP : BIT;
      end
      START: if (last_q) begin
        state_n = DONE;
        busy_n  = 1'b1;
      end
      STOP: if (last_q) begin
        state_n = DONE;
        busy_n  = 1'b0;
      end
      BIT: if (last_q) begin
        state_n = bc == 4'd8 ? DONE : BIT;
        bc_n    = bc + 4'd1;
      end
      default: state_n = IDLE;
    endcase
    // Level the master wants on SDA for the upcoming bit slot (1 = released).
    bitv  = bc_n < 4'd8 ? (rd_n ? 1'b1 : byt_n[3'd7 - bc_n[2:0]]) : (rd_n ? ~ack_m_n : 1'b1);
    scl_n = scl_r;
    sda_n = sda_r;
    // Pad levels are a function of the quarter being entered; unlisted cases hold.
    case (state_n)
      START: begin
        sda_n = q_n == 2'd0 ? 1'b0 : q_n == 2'd2 ? 1'b1 : sda_r;
        scl_n = q_n == 2'd1 ? 1'b0 : q_n == 2'd3 ? 1'b1 : scl_r;
      end
      BIT: begin
        scl_n = q_n == 2'd0 || q_n == 2'd3;
        sda_n = q_n == 2'd0 ? ~bitv : sda_r;
      end
      STOP: begin
        scl_n = q_n == 2'd0;
        sda_n = q_n == 2'd0 ? 1'b1 : q_n == 2'd2 ? 1'b0 : sda_r;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q          <= 2'd0;
      qc         <= 8'd0;
      bc         <= 4'd0;
      rd         <= 1'b0;
      byt        <= 8'd0;
      ack_m      <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      scl_r      <= 1'b0;
      sda_r      <= 1'b0;
      sh         <= 8'd0;
      ack_s      <= 1'b1;
      data_out_r <= 8'd0;
      ack_out_r  <= 1'b1;
    end else begin
      state  <= state_n;
      q      <= q_n;
      qc     <= qc_n;
      bc     <= bc_n;
      rd     <= rd_n;
      byt    <= byt_n;
      ack_m  <= ack_m_n;
      err_r  <= err_n;
      busy_r <= busy_n;
      scl_r  <= scl_n;
      sda_r  <= sda_n;
      // Sample on the last cycle of Q1, just before SCL has been high for a full quarter.
      if (state == BIT && q == 2'd1 && tick) begin
        if (bc < 4'd8) sh <= {sh[6:0], bus.sda_in};
        else ack_s <= bus.sda_in;
      end
      if (state == BIT && last_q && bc == 4'd8) begin
        if (rd) data_out_r <= sh;
        else ack_out_r <= ack_s;
      end
    end
  end
  assign bus.cmd_ready = state == IDLE;
  assign bus.done      = state == DONE;
  assign bus.err       = state == DONE && err_r;
  assign bus.busy      = busy_r;
  assign bus.scl_oe    = scl_r;
  assign bus.sda_oe    = sda_r;
  assign bus.data_out  = data_out_r;
  assign bus.ack_out   = ack_out_r;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed scoreboard bench for i2c_master_ctrl with a simple slave pad model
module tb_i2c_master_ctrl;
  localparam int K = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stretch = 1'b0;
  logic slave_sda = 1'b0;
  always #5 clk = ~clk;
  i2c_master_ctrl_if bus();
  assign bus.scl_in = ~(bus.scl_oe | stretch);
  assign bus.sda_in = ~(bus.sda_oe | slave_sda);
  i2c_master_ctrl #(.CLK_DIV(K)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    string      tag;
    int         lat;
    logic       err;
    logic       busy;
    logic       aux_en;
    logic [7:0] aux;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int rises, idx, scl_toggles, mode, st_cnt;
  logic [8:0] sda_at_rise;
  logic [7:0] sbyte, v;
  bit start_ok, stop_ok, do_stretch, st_done;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // mode: 0 slave idle, 1 write with slave ACK, 2 write with slave NACK, 3 slave sends sbyte
  task automatic run(input string tag, input logic [1:0] c, input logic [7:0] d, input logic a,
                     input int m, input logic [7:0] sdat, input int lat, input logic e,
                     input logic b, input logic aux_en, input logic [7:0] aux, input int stop_at = -1);
    exp_t x;
    logic scl_prev, sclo_prev, sdao_prev, scl_lvl, sda_lvl;
    bit got, aborted;
    int seen;
    sb.push_back('{tag, lat, e, b, aux_en, aux});
    mode = m; sbyte = sdat; rises = 0; idx = 0; scl_toggles = 0;
    sda_at_rise = '1; start_ok = 0; stop_ok = 0; st_done = 0; st_cnt = 0;
    got = 0; aborted = 0; seen = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd = c; bus.data_in = d; bus.ack_in = a;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    scl_prev = bus.scl_in; sclo_prev = bus.scl_oe; sdao_prev = bus.sda_oe;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (st_cnt > 0) begin stretch = 1'b1; st_cnt--; end else stretch = 1'b0;
      if (do_stretch && !st_done && rises == 0 && !bus.scl_oe) begin
        stretch = 1'b1; st_cnt = 19; st_done = 1;
      end
      scl_lvl = !(bus.scl_oe || stretch);
      sda_lvl = !(bus.sda_oe || slave_sda);
      if (scl_lvl && !scl_prev) begin
        if (rises < 9) sda_at_rise[rises] = sda_lvl;
        rises++;
      end
      if (!scl_lvl && scl_prev) idx++;
      if (bus.scl_oe != sclo_prev) scl_toggles++;
      if (bus.sda_oe && !sdao_prev && !bus.scl_oe) start_ok = 1;
      if (!bus.sda_oe && sdao_prev && !bus.scl_oe) stop_ok = 1;
      scl_prev = scl_lvl; sclo_prev = bus.scl_oe; sdao_prev = bus.sda_oe;
      if (stop_at >= 0 && idx == stop_at) begin aborted = 1; break; end
      slave_sda = (mode == 1 && idx == 8) || (mode == 3 && idx < 8 && !sbyte[7 - idx]);
      if (bus.done) begin got = 1; seen = n; break; end
    end
    if (aborted) void'(sb.pop_back());
    else if (!got) chk({tag, "_timeout"}, 0, 1);
    else begin
      x = sb.pop_front();
      chk({x.tag, "_latency"}, 32'(seen), 32'(x.lat));
      chk({x.tag, "_err"}, bus.err, x.err);
      chk({x.tag, "_busy"}, bus.busy, x.busy);
      if (x.aux_en) chk({x.tag, "_result"}, c == 2'd2 ? bus.data_out : {7'd0, bus.ack_out}, x.aux);
    end
    if (!aborted) slave_sda = 1'b0;
    stretch = 1'b0;
    for (int i = 0; i < 8; i++) v[7 - i] = sda_at_rise[i];
  endtask
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd = 2'd0; bus.data_in = 8'd0; bus.ack_in = 1'b0;
    do_stretch = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_scl_oe", bus.scl_oe, 0);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_ack_out", bus.ack_out, 1);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_done_err", {bus.done, bus.err}, 0);
    @(negedge clk) rst = 1'b0;
    run("start", 2'd0, 8'h00, 1'b0, 0, 8'h00, 4*K+1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("start_sda_fall_scl_high", start_ok, 1);
    chk("start_scl_low_after", bus.scl_oe, 1);
    run("wr_a5", 2'd1, 8'hA5, 1'b0, 1, 8'h00, 36*K+1, 1'b0, 1'b1, 1'b1, 8'h00);
    chk("wr_a5_sda_bits", v, 8'hA5);
    chk("wr_a5_ack_slot", sda_at_rise[8], 0);
    run("wr_nack", 2'd1, 8'h5A, 1'b0, 2, 8'h00, 36*K+1, 1'b0, 1'b1, 1'b1, 8'h01);
    run("rd_3c", 2'd2, 8'h00, 1'b0, 3, 8'h3C, 36*K+1, 1'b0, 1'b1, 1'b1, 8'h3C);
    chk("rd_3c_bits_on_bus", v, 8'h3C);
    chk("rd_nack_slot_released", sda_at_rise[8], 1);
    chk("rd_sda_oe_after", bus.sda_oe, 0);
    run("stop", 2'd3, 8'h00, 1'b0, 0, 8'h00, 4*K+1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("stop_sda_rise_scl_high", stop_ok, 1);
    chk("stop_pads_released", {bus.scl_oe, bus.sda_oe}, 0);
    run("wr_idle", 2'd1, 8'hFF, 1'b0, 0, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("wr_idle_no_scl", scl_toggles, 0);
    run("stop_idle", 2'd3, 8'h00, 1'b0, 0, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'h00);
`ifdef I2C_STRETCH_EN
    run("start_s", 2'd0, 8'h00, 1'b0, 0, 8'h00, 4*K+1, 1'b0, 1'b1, 1'b0, 8'h00);
    do_stretch = 1;
    run("wr_stretch", 2'd1, 8'hA5, 1'b0, 1, 8'h00, 36*K+1+20, 1'b0, 1'b1, 1'b1, 8'h00);
    do_stretch = 0;
    chk("wr_stretch_sda_bits", v, 8'hA5);
    run("stop_s", 2'd3, 8'h00, 1'b0, 0, 8'h00, 4*K+1, 1'b0, 1'b0, 1'b0, 8'h00);
`endif
    run("start_r", 2'd0, 8'h00, 1'b0, 0, 8'h00, 4*K+1, 1'b0, 1'b1, 1'b0, 8'h00);
    run("wr_abort", 2'd1, 8'hC3, 1'b0, 1, 8'h00, 36*K+1, 1'b0, 1'b1, 1'b1, 8'h00, 3);
    chk("abort_reached_bit3", idx, 3);
    rst = 1'b1;
    slave_sda = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_scl_oe", bus.scl_oe, 0);
    chk("abort_sda_oe", bus.sda_oe, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    chk("abort_done", bus.done, 0);
    @(negedge clk) rst = 1'b0;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
